// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/load controller for the single-cycle core.
//   Loads a program into instruction memory as pairs of 16-bit halfwords
//   (high half first), holds the core in reset while idle or loading, and
//   sequences run / single-step / stop with halt on a halt instruction or
//   a PC breakpoint.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cmd_valid/cmd        command strobe and code; cmd_ready is the handshake
//   load_words           word count, sampled when LOAD is accepted
//   signal, sig_valid    load halfword stream
//   bp_en, bp_addr       PC breakpoint
//   pc_out, inst         core PC and current instruction
//   core_rst, pc_en      core reset and advance/commit enable
//   imem_we/waddr/wdata  instruction-memory write port
//   halted, done         halt level and one-cycle halt-entry pulse
//   halt_cause           0 none, 1 halt insn, 2 breakpoint, 3 stop/step
//   cycle_cnt            saturating count of pc_en cycles
// 32-bit buses are numbered [0:31] with bit 0 the MSB.
module cpu_run_ctrl #(
    parameter int          IMEM_AW   = 6,
    parameter logic [0:31] HALT_INSN = 32'hFFFF_FFFF,
    parameter int          CYC_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd,
    output logic               cmd_ready,
    input  logic [IMEM_AW:0]   load_words,
    input  logic [15:0]        signal,
    input  logic               sig_valid,
    input  logic               bp_en,
    input  logic [0:31]        bp_addr,
    input  logic [0:31]        pc_out,
    input  logic [0:31]        inst,
    output logic               core_rst,
    output logic               pc_en,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [0:31]        imem_wdata,
    output logic               halted,
    output logic               done,
    output logic [1:0]         halt_cause,
    output logic [CYC_W-1:0]   cycle_cnt
);

    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_RUN   = 3'd2;
    localparam logic [2:0] CMD_STEP  = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;
    localparam logic [2:0] CMD_CLEAR = 3'd5;

    localparam logic [IMEM_AW:0] DEPTH = {1'b1, {IMEM_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_HI, S_LOAD_LO, S_LOAD_WR, S_RUN, S_STEP, S_HALT
    } state_t;

    state_t           state;
    logic [IMEM_AW:0] n_words;
    logic             first_cycle;
    logic             fire, is_halt, bp_hit, halt_cond;

    assign core_rst  = (state == S_IDLE) || (state == S_LOAD_HI) ||
                       (state == S_LOAD_LO) || (state == S_LOAD_WR);
    assign cmd_ready = (state == S_IDLE) || (state == S_RUN) || (state == S_HALT);
    assign imem_we   = (state == S_LOAD_WR);
    assign halted    = (state == S_HALT);
    assign fire      = cmd_valid && cmd_ready;

    // Breakpoint is masked on the first RUN cycle so a resume from the
    // breakpoint PC executes that instruction instead of halting again.
    assign is_halt   = (inst == HALT_INSN);
    assign bp_hit    = bp_en && (pc_out == bp_addr) && !first_cycle;
    assign halt_cond = is_halt || bp_hit;

    always_comb begin
        pc_en = 1'b0;
        case (state)
            S_RUN:   pc_en = !halt_cond;
            S_STEP:  pc_en = !is_halt;
            default: pc_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            n_words     <= '0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            first_cycle <= 1'b0;
            done        <= 1'b0;
            halt_cause  <= 2'd0;
            cycle_cnt   <= '0;
        end else begin
            done        <= 1'b0;
            first_cycle <= 1'b0;
            if (pc_en && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (fire) begin
                        case (cmd)
                            CMD_LOAD: begin
                                n_words    <= (load_words > DEPTH) ? DEPTH : load_words;
                                imem_waddr <= '0;
                                if (load_words != '0)
                                    state <= S_LOAD_HI;
                            end
                            CMD_RUN: begin
                                state       <= S_RUN;
                                first_cycle <= 1'b1;
                            end
                            CMD_STEP:  state <= S_STEP;
                            CMD_CLEAR: begin
                                cycle_cnt  <= '0;
                                halt_cause <= 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOAD_HI: begin
                    if (sig_valid) begin
                        imem_wdata[0:15] <= signal;
                        state            <= S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    if (sig_valid) begin
                        imem_wdata[16:31] <= signal;
                        state             <= S_LOAD_WR;
                    end
                end
                S_LOAD_WR: begin
                    if ({1'b0, imem_waddr} == n_words - 1'b1) begin
                        state <= S_IDLE;
                    end else begin
                        imem_waddr <= imem_waddr + 1'b1;
                        state      <= S_LOAD_HI;
                    end
                end
                S_RUN: begin
                    // A halt condition outranks a coincident STOP.
                    if (halt_cond) begin
                        state      <= S_HALT;
                        done       <= 1'b1;
                        halt_cause <= is_halt ? 2'd1 : 2'd2;
                    end else if (fire && cmd == CMD_STOP) begin
                        state      <= S_HALT;
                        done       <= 1'b1;
                        halt_cause <= 2'd3;
                    end
                end
                S_STEP: begin
                    state      <= S_HALT;
                    done       <= 1'b1;
                    halt_cause <= is_halt ? 2'd1 : 2'd3;
                end
                S_HALT: begin
                    if (fire) begin
                        case (cmd)
                            CMD_RUN: begin
                                state       <= S_RUN;
                                first_cycle <= 1'b1;
                            end
                            CMD_STEP:  state <= S_STEP;
                            CMD_CLEAR: begin
                                state      <= S_IDLE;
                                cycle_cnt  <= '0;
                                halt_cause <= 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed load/reset/edge sequences, a table of
// run/halt/step vectors with hand-derived expectations, and a randomized
// phase, all cross-checked every cycle against a behavioural model.
module tb_cpu_run_ctrl;
    localparam int          AW   = 6;
    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [31:0] HI   = 32'hFFFF_FFFF;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = '0;
    logic          cmd_ready;
    logic [AW:0]   load_words = '0;
    logic [15:0]   signal = '0;
    logic          sig_valid = 1'b0, bp_en = 1'b0;
    logic [31:0]   bp_addr = '0, pc_out = '0, inst = '0;
    logic          core_rst, pc_en, imem_we, halted, done;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [1:0]    halt_cause;
    logic [CW-1:0] cycle_cnt;

    cpu_run_ctrl #(.IMEM_AW(AW), .HALT_INSN(HI), .CYC_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .load_words(load_words), .signal(signal), .sig_valid(sig_valid),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc_out(pc_out), .inst(inst),
        .core_rst(core_rst), .pc_en(pc_en), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .halted(halted), .done(done), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 loading, 2 running, 3 stepping, 4 halted.
    // Loading is tracked as a queue of collected halfwords; a full pair means
    // the write happens this cycle.
    int          m_mode, m_n, m_wr, m_cause, m_cnt;
    logic [15:0] m_q[$];
    bit          m_first, m_done;
    bit          e_rdy, e_pe, e_hc, e_ins;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    wr_t wr_log[$];

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_wr = 0; m_cause = 0; m_cnt = 0;
        m_first = 0; m_done = 0; m_q.delete();
    endtask

    task automatic model_check();
        bit we;
        e_ins = (inst == HI);
        e_rdy = (m_mode == 0) || (m_mode == 2) || (m_mode == 4);
        e_hc  = e_ins || (bp_en && pc_out == bp_addr && !m_first);
        e_pe  = (m_mode == 2) ? !e_hc : (m_mode == 3) ? !e_ins : 1'b0;
        we    = (m_mode == 1) && (m_q.size() == 2);
        chk("cmd_ready", cmd_ready, e_rdy);
        chk("core_rst", core_rst, m_mode <= 1);
        chk("pc_en", pc_en, e_pe);
        chk("imem_we", imem_we, we);
        chk("halted", halted, m_mode == 4);
        chk("done", done, m_done);
        chk("halt_cause", halt_cause, m_cause);
        chk("cycle_cnt", cycle_cnt, m_cnt);
        if (we) begin
            chk("imem_waddr", imem_waddr, m_wr);
            chk("imem_wdata", imem_wdata, {m_q[0], m_q[1]});
        end
    endtask

    task automatic model_adv();
        bit fire;
        fire   = cmd_valid && e_rdy;
        m_done = 0;
        if (e_pe && m_cnt < CMAX) m_cnt++;
        case (m_mode)
            0: if (fire) begin
                if (cmd == 1) begin
                    m_n = (load_words > (1 << AW)) ? (1 << AW) : int'(load_words);
                    m_wr = 0; m_q.delete();
                    if (m_n > 0) m_mode = 1;
                end else if (cmd == 2) begin m_mode = 2; m_first = 1; end
                else if (cmd == 3) m_mode = 3;
                else if (cmd == 5) begin m_cnt = 0; m_cause = 0; end
            end
            1: if (m_q.size() == 2) begin
                m_q.delete(); m_wr++;
                if (m_wr == m_n) m_mode = 0;
            end else if (sig_valid) m_q.push_back(signal);
            2: begin
                m_first = 0;
                if (e_hc) begin m_mode = 4; m_done = 1; m_cause = e_ins ? 1 : 2; end
                else if (fire && cmd == 4) begin m_mode = 4; m_done = 1; m_cause = 3; end
            end
            3: begin m_mode = 4; m_done = 1; m_cause = e_ins ? 1 : 3; end
            4: if (fire) begin
                if (cmd == 2) begin m_mode = 2; m_first = 1; end
                else if (cmd == 3) m_mode = 3;
                else if (cmd == 5) begin m_mode = 0; m_cnt = 0; m_cause = 0; end
            end
            default: ;
        endcase
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled 1ns
    // before the rising edge.
    task automatic pre();
        #4;
        model_check();
        if (imem_we) wr_log.push_back('{imem_waddr, imem_wdata});
    endtask

    task automatic post();
        model_adv();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        pre(); post();
    endtask

    task automatic send(input logic [2:0] c);
        cmd_valid = 1; cmd = c; step(); cmd_valid = 0; cmd = 0;
    endtask

    typedef struct {
        bit cv; logic [2:0] c; bit hinst; logic [31:0] pc; bit bpe;
        bit pe, crst, hl, dn; logic [1:0] cause; logic [3:0] cnt;
    } vec_t;
    vec_t tbl[21];

    logic [15:0] hw[4];
    int n0;

    initial begin
        // cv c hinst pc bpe | pc_en core_rst halted done cause cnt
        tbl[0]  = '{1, 2, 0,  0, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,  4, 0, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0,  8, 0, 1, 0, 0, 0, 0, 2};
        tbl[4]  = '{0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 3};
        tbl[5]  = '{0, 0, 0, 12, 0, 0, 0, 1, 1, 1, 3};
        tbl[6]  = '{0, 0, 0, 12, 0, 0, 0, 1, 0, 1, 3};
        tbl[7]  = '{1, 5, 0, 12, 1, 0, 0, 1, 0, 1, 3};
        tbl[8]  = '{1, 2, 0,  0, 1, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0,  4, 1, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0,  8, 1, 0, 0, 0, 0, 0, 2};
        tbl[12] = '{1, 2, 0,  8, 1, 0, 0, 1, 1, 2, 2};
        tbl[13] = '{0, 0, 0,  8, 1, 1, 0, 0, 0, 2, 2};
        tbl[14] = '{0, 0, 0, 12, 1, 1, 0, 0, 0, 2, 3};
        tbl[15] = '{1, 4, 0, 16, 1, 1, 0, 0, 0, 2, 4};
        tbl[16] = '{1, 3, 0, 16, 1, 0, 0, 1, 1, 3, 5};
        tbl[17] = '{0, 0, 0, 20, 1, 1, 0, 0, 0, 3, 5};
        tbl[18] = '{1, 2, 0, 20, 1, 0, 0, 1, 1, 3, 6};
        tbl[19] = '{1, 4, 1, 24, 1, 0, 0, 0, 0, 3, 6};
        tbl[20] = '{0, 0, 0, 24, 1, 0, 0, 1, 1, 1, 6};

        // Reset values
        #1;
        chk("rst core_rst", core_rst, 1);
        chk("rst pc_en", pc_en, 0);
        chk("rst imem_we", imem_we, 0);
        chk("rst waddr", imem_waddr, 0);
        chk("rst wdata", imem_wdata, 0);
        chk("rst halted", halted, 0);
        chk("rst done", done, 0);
        chk("rst cause", halt_cause, 0);
        chk("rst cnt", cycle_cnt, 0);
        @(negedge clk);
        rst = 0;
        model_reset();

        // Two-word load with gaps in sig_valid
        hw[0] = 16'h1234; hw[1] = 16'h5678; hw[2] = 16'h9ABC; hw[3] = 16'hDEF0;
        wr_log.delete();
        load_words = 2;
        send(1);
        for (int i = 0; i < 4; i++) begin
            step();
            sig_valid = 1; signal = hw[i]; step(); sig_valid = 0;
        end
        step(); step();
        chk("load count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("load a0", wr_log[0].a, 0);
            chk("load d0", wr_log[0].d, 32'h12345678);
            chk("load a1", wr_log[1].a, 1);
            chk("load d1", wr_log[1].d, 32'h9ABCDEF0);
        end

        // Run / halt / breakpoint / step / stop vectors
        bp_addr = 8;
        foreach (tbl[i]) begin
            cmd_valid = tbl[i].cv; cmd = tbl[i].c;
            inst = tbl[i].hinst ? HI : 32'h0000_0013;
            pc_out = tbl[i].pc; bp_en = tbl[i].bpe;
            pre();
            chk($sformatf("tbl%0d pc_en", i), pc_en, tbl[i].pe);
            chk($sformatf("tbl%0d core_rst", i), core_rst, tbl[i].crst);
            chk($sformatf("tbl%0d halted", i), halted, tbl[i].hl);
            chk($sformatf("tbl%0d done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d cause", i), halt_cause, tbl[i].cause);
            chk($sformatf("tbl%0d cnt", i), cycle_cnt, tbl[i].cnt);
            post();
        end
        cmd_valid = 0; inst = 0; bp_en = 0;

        // Asynchronous reset with a fully assembled but unwritten word
        n0 = wr_log.size();
        load_words = 1;
        send(1);
        sig_valid = 1; signal = 16'hAAAA; step();
        signal = 16'hBBBB; step(); sig_valid = 0;
        rst = 1;
        #1;
        chk("mid rst core_rst", core_rst, 1);
        chk("mid rst imem_we", imem_we, 0);
        chk("mid rst waddr", imem_waddr, 0);
        chk("mid rst wdata", imem_wdata, 0);
        chk("mid rst ready", cmd_ready, 1);
        chk("mid rst cnt", cycle_cnt, 0);
        chk("mid rst cause", halt_cause, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        step(); step();
        chk("mid rst no write", wr_log.size(), n0);

        // Zero-length load
        n0 = wr_log.size();
        load_words = 0;
        send(1);
        step(); step(); step();
        chk("n0 no write", wr_log.size(), n0);

        // Oversized load clamps to the memory depth
        n0 = wr_log.size();
        load_words = (1 << AW) + 1;
        send(1);
        for (int k = 0; k < 400 && m_mode == 1; k++) begin
            sig_valid = 1; signal = 16'($urandom); step();
        end
        sig_valid = 0;
        step();
        chk("clamp done", cmd_ready, 1);
        chk("clamp count", wr_log.size() - n0, 1 << AW);
        if (wr_log.size() > 0)
            chk("clamp last addr", wr_log[wr_log.size() - 1].a, (1 << AW) - 1);

        // Randomized phase against the model
        bp_addr = 8;
        for (int k = 0; k < 3000; k++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd        = 3'($urandom_range(0, 7));
            load_words = 7'($urandom_range(0, 3));
            sig_valid  = 1'($urandom_range(0, 1));
            signal     = 16'($urandom);
            bp_en      = 1'($urandom_range(0, 1));
            pc_out     = 32'(4 * $urandom_range(0, 4));
            inst       = ($urandom_range(0, 9) == 0) ? HI : $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
